imem_loader: RTL
================

# imem_loader

Boot-time controller for the single-cycle CPU's instruction memory. It holds the CPU in stall, receives a program as a byte stream over a valid/ready handshake, packs four bytes into each 32-bit word, and writes the words to consecutive instruction-memory word addresses. After the last word is written, it releases the CPU and routes the CPU fetch address to the memory address port.

## Interface

Parameters:
- AW, 5: instruction-memory word-address width. This is the memory index, taken from address bits [AW+1:2].
- DEPTH, 32: number of words loaded per session. Legal range is 1..2^AW.

Ports:
- clk, in, 1: single clock. All state changes on the rising edge.
- clrn, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle pulse that begins a load session.
- in_data, in, 8: stream byte.
- in_valid, in, 1: in_data is valid.
- in_ready, out, 1: loader accepts a byte. A transfer occurs when in_valid & in_ready at a rising edge.
- cpu_a, in, 32: CPU fetch byte address.
- mem_addr, out, AW: instruction-memory word address.
- mem_wdata, out, 32: write data.
- mem_we, out, 1: write enable, one-cycle pulse per word.
- cpu_hold, out, 1: CPU stall/hold.
- busy, out, 1: a load session is in progress.
- done, out, 1: the last load completed.
- err, out, 1: checksum mismatch. Only driven when the CHECKSUM_EN macro is defined, otherwise constant 0.

## Operation

States:
- IDLE
  - Entered on reset. cpu_hold=1, in_ready=0.
  - start → LOAD.
- LOAD
  - in_ready=1, busy=1, cpu_hold=1.
  - Bytes are packed little-endian: the first byte goes to [7:0], the fourth byte to [31:24].
  - On acceptance of the 4th byte:
    - The assembled word is registered into mem_wdata.
    - mem_we=1 for the next cycle only, with mem_addr = word pointer.
    - The pointer increments after that write cycle.
  - The byte counter wraps 3→0. in_ready stays 1 during the write cycle, so the next word's byte 0 may be accepted then.
  - After the write cycle of word DEPTH-1, the next state is CHK if the CHECKSUM_EN macro is defined, otherwise DONE.
- CHK (only when the CHECKSUM_EN macro is defined)
  - Accepts 4 more bytes, packed little-endian as the expected checksum. No memory write.
  - err is registered as (expected ≠ running sum).
  - → DONE.
- DONE
  - cpu_hold=0, done=1, busy=0, in_ready=0, mem_we=0.
  - mem_addr = cpu_a[AW+1:2], combinational.
  - start → LOAD. The session restart clears done and err, and sets the pointer and byte counter to 0.

Rules:
- start in LOAD or CHK is ignored.
- Bytes presented while in_ready=0 are not consumed.
- mem_addr outside DONE:
  - It equals the word pointer.
  - A pointer of DEPTH is never driven.
  - No pointer wrap occurs when DEPTH=2^AW, because the pointer is (AW+1) bits wide.
- Reset at any time, including mid-word, mid-write or during CHK:
  - Returns to IDLE immediately.
  - Pointer and byte counter are set to 0, and mem_we=0.
  - A partial word is discarded.
- Reset values of outputs: in_ready=0, mem_we=0, mem_wdata=0, mem_addr=0, cpu_hold=1, busy=0, done=0, err=0.

## Timing

- start sampled at edge N gives in_ready=1 from cycle N+1.
- 4th byte of word k accepted at edge M:
  - mem_we=1, mem_addr=k, mem_wdata=word k during cycle M+1.
  - mem_we=0 from M+2 unless another word completes.
- Minimum of 4 cycles per word, so writes never overlap.
- The last write cycle ends at edge L, and the state is DONE (or CHK) from L. done=1 and cpu_hold=0 are visible in the cycle after L.
- Checksum verdict: err and done are both valid in the same cycle, one cycle after the 4th checksum byte is accepted.

## Configuration

- CHECKSUM_EN defined:
  - Maintains a 32-bit running sum, modulo 2^32, of all written words.
  - Adds the CHK state and drives err.
- CHECKSUM_EN undefined:
  - No adder and no CHK state.
  - err tied to 0, and LOAD → DONE directly.

## Structure

- Package imem_loader_pkg contains:
  - The state enum: IDLE, LOAD, CHK, DONE.
  - BYTES_PER_WORD=4.
  - The byte-counter width of 2.
- Sub-module byte_packer contains:
  - The 8→32 little-endian shift/pack register.
  - The byte counter.
  - A word_valid pulse output.
- The controller FSM, pointer, address mux and checksum stay in imem_loader.

## Test plan

- **Reset:** hold clrn=0, then release. Outputs must be cpu_hold=1, in_ready=0, mem_we=0, mem_addr=0, done=0, err=0. The state must stay IDLE without start.
- **Full load (DEPTH=32):** pulse start, stream bytes 0x00..0x7F with in_valid constantly 1.
  - Exactly 32 mem_we pulses.
  - addr0 = 0x03020100; addr31 = 0x7F7E7D7C.
  - done=1 and cpu_hold=0 one cycle after the last write.
- **Backpressure / gaps:** same stream with in_valid randomly deasserted, plus a start pulse mid-LOAD.
  - Identical 32 writes and contents.
  - The extra start has no effect.
- **Checksum (CHECKSUM_EN):**
  - Correct trailing sum → done=1, err=0.
  - Same stream with byte 5 changed to 0xFF → done=1, err=1.
  - A restart via start clears err to 0.
- **Reset mid-operation:** clrn pulsed low after word 10's 2nd byte.
  - Immediate IDLE and mem_we=0.
  - A new start and full stream then rewrites from addr 0, with 32 writes.
- **Address mux:** in DONE, cpu_a=0x0000007C gives mem_addr=31, and cpu_a=0x00000004 gives mem_addr=1.
  - start from DONE gives cpu_hold=1 and mem_addr=0 next cycle.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The CHECKSUM_EN macro enables the trailing checksum phase in imem_loader.
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CHK  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an 8-bit stream little-endian into 32-bit words and pulses word_valid
// in the cycle after the fourth byte of a word is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        last_byte,
  output logic [31:0] assembled
);

  logic [BCNT_W-1:0] count;
  logic [23:0]       shift_q;

  // Earlier bytes shift down, so the first byte of a word ends up in [7:0].
  assign last_byte = accept && (count == BCNT_W'(BYTES_PER_WORD - 1));
  assign assembled = {data, shift_q};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count      <= '0;
      shift_q    <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else if (clear) begin
      count      <= '0;
      shift_q    <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= last_byte;
      if (accept) begin
        count   <= count + BCNT_W'(1);
        shift_q <= {data, shift_q[23:8]};
      end
      if (last_byte) begin
        word <= assembled;
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: stalls the CPU, streams a program into instruction memory, then
// hands the memory address port to the CPU. Optional checksum via CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          start,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   cpu_a,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_we,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    dbg_state
);

  localparam logic [AW:0] LAST_PTR = (AW + 1)'(DEPTH - 1);

  state_e      state;
  logic [AW:0] ptr;
  logic        accept;
  logic        restart;
  logic        word_valid;
  logic        last_byte;
  logic        last_wr;
  logic [31:0] word;
  logic [31:0] assembled;
  logic        unused;

  // Handshake: a byte transfers on a rising edge where in_valid && in_ready.
  assign accept  = in_valid && in_ready;
  assign restart = start && ((state == IDLE) || (state == DONE));

  byte_packer u_packer (
    .clk        (clk),
    .clrn       (clrn),
    .clear      (restart),
    .accept     (accept),
    .data       (in_data),
    .word       (word),
    .word_valid (word_valid),
    .last_byte  (last_byte),
    .assembled  (assembled)
  );

  // No byte is taken during the final write cycle: the session is over after it.
  assign last_wr   = word_valid && (state == LOAD) && (ptr == LAST_PTR);
  assign in_ready  = ((state == LOAD) && !last_wr) || (state == CHK);
  assign mem_we    = word_valid && (state == LOAD);
  assign mem_wdata = word;
  assign mem_addr  = (state == DONE) ? cpu_a[AW+1:2] : ptr[AW-1:0];
  assign cpu_hold  = (state != DONE);
  assign busy      = (state == LOAD) || (state == CHK);
  assign done      = (state == DONE);
  assign dbg_state = state;

  assign unused = ^{cpu_a[31:AW+2], cpu_a[1:0], assembled};

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= LOAD;
            ptr   <= '0;
          end
        end
        LOAD: begin
          if (mem_we) begin
            if (ptr == LAST_PTR) begin
`ifdef CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
`endif
            end else begin
              ptr <= ptr + (AW + 1)'(1);
            end
          end
        end
        CHK: begin
          if (last_byte) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHECKSUM_EN
  logic [31:0] sum;
  logic        err_q;

  // The verdict is taken from the combinational word so it lands with done.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (restart) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else begin
      if (mem_we) sum <= sum + word;
      if ((state == CHK) && last_byte) err_q <= (assembled != sum);
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
